// File: rtl/demux_load_sequencer_if.sv
// Stream-in / demux-out bundle for demux_load_sequencer.
// master = upstream source and demux consumer side, slave = the sequencer.
interface demux_load_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [3:0]        sel;
    logic              en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, sel, en, wr_data, busy, done
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, sel, en, wr_data, busy, done
    );
endinterface

// File: rtl/demux_load_sequencer.sv
// Frame loader driving a 1-to-16 enable demux: one slot write per accepted word.
// Optional SEQ_OVERRUN_EN adds a sticky overrun flag for words offered outside LOAD.
module demux_load_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NUM_SLOTS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_load_sequencer_if.slave  bus
`ifdef SEQ_OVERRUN_EN
    ,
    output logic                   overrun
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_SLOTS - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        sel;
    logic              en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              accept;

    assign accept      = bus.s_valid && (state == LOAD);
    assign bus.s_ready = (state == LOAD);
    assign bus.sel     = sel;
    assign bus.en      = en;
    assign bus.wr_data = wr_data;
    assign bus.busy    = busy;
    assign bus.done    = done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            sel     <= 4'd0;
            en      <= 1'b0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            en   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        en      <= 1'b1;
                        sel     <= cnt;
                        wr_data <= bus.s_data;
                        cnt     <= cnt + 4'd1;
                        // done is raised with the last en so it is high exactly in DONE
                        if (cnt == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_OVERRUN_EN
    // Clearing on frame start wins over a word offered in that same IDLE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            overrun <= 1'b0;
        end else if (bus.s_valid && state != LOAD) begin
            overrun <= 1'b1;
        end
    end
`endif
endmodule
